// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, RTS, odd parity, ACK check, timeout)
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 50,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic [1:0] clk_sync, data_sync;
  logic [FW-1:0] flt_cnt;
  logic clk_f, clk_f_d, fall, timeout, accept;
  logic [9:0] sh;
  logic [3:0] ec;
  logic [IW-1:0] ic;
  logic [TW-1:0] tmr;
  assign tx_ready = state == IDLE;
  assign busy = ~tx_ready;
  assign accept = tx_valid & tx_ready;
  assign fall = clk_f_d & ~clk_f;
  assign timeout = tmr == TW'(TIMEOUT_CYCLES);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_sync <= 2'b11;
      data_sync <= 2'b11;
      flt_cnt <= '0;
      clk_f <= 1'b1;
      clk_f_d <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
      clk_f_d <= clk_f;
      flt_cnt <= (clk_sync[1] == clk_f || flt_cnt == FW'(FILTER_LEN - 1)) ? '0 : flt_cnt + 1'b1;
      if (clk_sync[1] != clk_f && flt_cnt == FW'(FILTER_LEN - 1))
        clk_f <= clk_sync[1];
    end
  always_comb begin
    state_n = state;
    done = 1'b0;
    err = 1'b0;
    if (timeout) begin
      state_n = IDLE;
      err = 1'b1;
    end else
      case (state)
        IDLE:      state_n = accept ? INHIBIT : IDLE;
        INHIBIT:   state_n = (ic == IW'(INHIBIT_CYCLES - 1)) ? RTS : INHIBIT;
        RTS:       state_n = fall ? SHIFT : RTS;
        SHIFT:     state_n = (fall && ec == 4'd9) ? ACK : SHIFT;
        ACK: if (fall) begin
          state_n = data_sync[1] ? IDLE : WAIT_IDLE;
          err = data_sync[1];
        end
        WAIT_IDLE: if (clk_f && data_sync[1]) begin
          state_n = IDLE;
          done = 1'b1;
        end
        default:   state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      ec <= '0;
      ic <= '0;
      tmr <= '0;
      err_code <= 2'b00;
      ps2_clk_oe <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state <= state_n;
      ic <= (state == INHIBIT) ? ic + 1'b1 : '0;
      tmr <= (state == IDLE || state == INHIBIT) ? '0 : tmr + 1'b1;
      if (accept)
        err_code <= 2'b00;
      else if (timeout)
        err_code <= 2'b10;
      else if (err)
        err_code <= 2'b01;
      if (accept)
        sh <= {1'b1, ~^tx_data, tx_data};
      else if (fall && state_n == SHIFT)
        sh <= sh >> 1;
      if (state == INHIBIT)
        ec <= '0;
      else if (fall && state_n == SHIFT)
        ec <= ec + 1'b1;
      ps2_clk_oe <= state_n == INHIBIT;
      if (state_n == RTS)
        ps2_data_oe <= 1'b1;
      else if (state_n != SHIFT)
        ps2_data_oe <= 1'b0;
      else if (fall)
        ps2_data_oe <= ~sh[0];
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a PS/2 device model clocking, sampling and ACKing host frames
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 300, TMO = 6000, FLT = 8, H = 40;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe;
  logic [1:0] err_code;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic ps2_clk_i, ps2_data_i;
  logic clk_oe_d = 1'b0;
  logic exp_q[$];
  int vectors = 0, misses = 0;
  int cyc = 0, inh_run = 0, inh_len = 0, rts_cyc = 0, err_cyc = 0, done_cnt = 0, err_cnt = 0;
  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;
  always #5 clk = ~clk;
  ps2_host_tx #(
    .CLK_FREQ_HZ(100_000_000),
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(FLT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code),
    .ps2_clk_i(ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );
  always @(negedge clk) begin
    cyc <= cyc + 1;
    clk_oe_d <= ps2_clk_oe;
    if (ps2_clk_oe)
      inh_run <= inh_run + 1;
    else if (inh_run != 0) begin
      inh_len <= inh_run;
      inh_run <= 0;
    end
    if (ps2_data_oe && clk_oe_d)
      rts_cyc <= cyc;
    if (done)
      done_cnt <= done_cnt + 1;
    if (err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (tx_ready !== 1'b1) begin
      misses++;
      $display("FAIL %s_ready: tx_ready=%b want 1", tag, tx_ready);
    end
  endtask
  task automatic send(input logic [7:0] b);
    wait_ready("send");
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 8; i++)
      exp_q.push_back(b[i]);
    exp_q.push_back(~^b);
    exp_q.push_back(1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask
  task automatic device(input logic ack, input int nbits, input logic glitch);
    int n;
    logic e;
    n = 0;
    while (!(ps2_clk_i === 1'b1 && ps2_data_i === 1'b0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!(ps2_clk_i === 1'b1 && ps2_data_i === 1'b0)) begin
      misses++;
      $display("FAIL rts: clk=%b data=%b want 1 0", ps2_clk_i, ps2_data_i);
      return;
    end
    repeat (50) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
      vectors++;
      if (ps2_data_i !== e) begin
        misses++;
        $display("FAIL bit%0d: sampled %b want %b", i, ps2_data_i, e);
      end
      repeat (20) @(negedge clk);
      if (glitch) begin
        dev_clk = 1'b0;
        repeat (4) @(negedge clk);
        dev_clk = 1'b1;
      end
      repeat (glitch ? H - 24 : H - 20) @(negedge clk);
    end
    if (nbits < 10)
      return;
    dev_data = ~ack;
    repeat (H / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    dev_clk = 1'b1;
    repeat (H / 2) @(negedge clk);
    dev_data = 1'b1;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if ({tx_ready, busy, done, err, err_code, ps2_clk_oe, ps2_data_oe} !== 8'b1000_0000) begin
      misses++;
      $display("FAIL reset: outputs=%b want 10000000",
               {tx_ready, busy, done, err, err_code, ps2_clk_oe, ps2_data_oe});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_byte(input logic [7:0] b, input logic glitch);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(b);
    device(1'b1, 10, glitch);
    wait_ready("byte");
    repeat (2) @(negedge clk);
    vectors++;
    if (inh_len != INH) begin
      misses++;
      $display("FAIL inhibit_%h: clk_oe low %0d cycles want %0d", b, inh_len, INH);
    end
    vectors++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      misses++;
      $display("FAIL done_%h: done pulses %0d err pulses %0d want 1 0", b, done_cnt - d0, err_cnt - e0);
    end
    vectors++;
    if ({err_code, ps2_clk_oe, ps2_data_oe} !== 4'b0000 || exp_q.size() != 0) begin
      misses++;
      $display("FAIL end_%h: err_code=%b oe=%b%b left=%0d want 00 00 0",
               b, err_code, ps2_clk_oe, ps2_data_oe, exp_q.size());
    end
  endtask
  task automatic test_nack;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hF4);
    device(1'b0, 10, 1'b0);
    wait_ready("nack");
    repeat (2) @(negedge clk);
    vectors++;
    if (err_cnt - e0 != 1 || done_cnt != d0 || err_code !== 2'b01) begin
      misses++;
      $display("FAIL nack: err pulses %0d done pulses %0d err_code=%b want 1 0 01",
               err_cnt - e0, done_cnt - d0, err_code);
    end
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      misses++;
      $display("FAIL nack_release: oe=%b%b want 00", ps2_clk_oe, ps2_data_oe);
    end
  endtask
  task automatic test_timeout;
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hF4);
    exp_q.delete();
    n = 0;
    while (err_cnt == e0 && n < INH + TMO + 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (err_cnt - e0 != 1 || done_cnt != d0 || err_code !== 2'b10) begin
      misses++;
      $display("FAIL timeout: err pulses %0d done pulses %0d err_code=%b want 1 0 10",
               err_cnt - e0, done_cnt - d0, err_code);
    end
    vectors++;
    if (err_cyc - rts_cyc != TMO) begin
      misses++;
      $display("FAIL timeout_time: err %0d cycles after RTS want %0d", err_cyc - rts_cyc, TMO);
    end
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
      misses++;
      $display("FAIL timeout_release: oe=%b%b tx_ready=%b want 00 1", ps2_clk_oe, ps2_data_oe, tx_ready);
    end
  endtask
  task automatic test_reset_mid;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hF4);
    device(1'b1, 4, 1'b0);
    vectors++;
    if (ps2_data_oe !== 1'b1) begin
      misses++;
      $display("FAIL mid_shift: data_oe=%b want 1 before reset", ps2_data_oe);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy} !== 4'b0010) begin
      misses++;
      $display("FAIL async_reset: oe=%b%b tx_ready=%b busy=%b want 00 1 0",
               ps2_clk_oe, ps2_data_oe, tx_ready, busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (5) @(negedge clk);
    vectors++;
    if (done_cnt != d0 || err_cnt != e0) begin
      misses++;
      $display("FAIL reset_pulse: done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0);
    end
    test_byte(8'hF4, 1'b0);
  endtask
  task automatic test_ignore_glitch;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hF4);
    repeat (10) @(negedge clk);
    tx_data = 8'hAA;
    tx_valid = 1'b1;
    vectors++;
    if (tx_ready !== 1'b0) begin
      misses++;
      $display("FAIL busy_ready: tx_ready=%b want 0", tx_ready);
    end
    repeat (20) @(negedge clk);
    tx_valid = 1'b0;
    tx_data = 8'h00;
    device(1'b1, 10, 1'b1);
    wait_ready("ignore");
    repeat (50) @(negedge clk);
    vectors++;
    if (done_cnt - d0 != 1 || err_cnt != e0 || busy !== 1'b0 || exp_q.size() != 0) begin
      misses++;
      $display("FAIL ignore: done %0d err %0d busy=%b left=%0d want 1 0 0 0",
               done_cnt - d0, err_cnt - e0, busy, exp_q.size());
    end
  endtask
  initial begin
    test_reset;
    test_byte(8'hF4, 1'b0);
    test_byte(8'hFF, 1'b0);
    test_byte(8'h00, 1'b0);
    test_nack;
    test_timeout;
    test_reset_mid;
    test_ignore_glitch;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
